// File: rtl/wbdbg_ctrl_if.sv
// ---------------------------------------------------------------------------
// wbdbg_ctrl_if
//   Bundles every non-clock signal of the Wishbone debug run controller:
//   host commands, trigger setup, the monitor control/strobe path, the host
//   byte link and the status counters.
//
//   Signals (direction as seen by the controller, i.e. the slave modport):
//     i_cmd_arm     in   1         pulse: start a capture session
//     i_cmd_stop    in   1         pulse: end the session
//     i_trig_adr    in   ADDRBITS  trigger address
//     i_trig_mask   in   ADDRBITS  trigger compare mask (1 = compare bit)
//     i_cap_limit   in   CNTBITS   transactions to capture, 0 = unlimited
//     o_dbg_rst     out  1         monitor reset
//     o_dbg_en      out  1         monitor enable
//     i_dbg_stb     in   1         monitor transaction strobe
//     i_dbg_txn     in   BUSBITS   monitor transaction word
//     o_byte_valid  out  1         byte available to the host
//     o_byte_data   out  8         byte to the host
//     i_byte_ready  in   1         host accepts the byte
//     o_state       out  3         controller state
//     o_cap_count   out  CNTBITS   transactions buffered this session
//     o_drop_count  out  8         transactions lost to a full buffer
//
//   Modports: slave = the controller, master = the host/monitor side.
// ---------------------------------------------------------------------------
interface wbdbg_ctrl_if #(
    parameter int ADDRBITS = 26,
    parameter int BUSBITS  = 72,
    parameter int CNTBITS  = 16
);
    logic                i_cmd_arm;
    logic                i_cmd_stop;
    logic [ADDRBITS-1:0] i_trig_adr;
    logic [ADDRBITS-1:0] i_trig_mask;
    logic [CNTBITS-1:0]  i_cap_limit;
    logic                o_dbg_rst;
    logic                o_dbg_en;
    logic                i_dbg_stb;
    logic [BUSBITS-1:0]  i_dbg_txn;
    logic                o_byte_valid;
    logic [7:0]          o_byte_data;
    logic                i_byte_ready;
    logic [2:0]          o_state;
    logic [CNTBITS-1:0]  o_cap_count;
    logic [7:0]          o_drop_count;

    modport slave (
        input  i_cmd_arm, i_cmd_stop, i_trig_adr, i_trig_mask, i_cap_limit,
        input  i_dbg_stb, i_dbg_txn, i_byte_ready,
        output o_dbg_rst, o_dbg_en, o_byte_valid, o_byte_data,
        output o_state, o_cap_count, o_drop_count
    );

    modport master (
        output i_cmd_arm, i_cmd_stop, i_trig_adr, i_trig_mask, i_cap_limit,
        output i_dbg_stb, i_dbg_txn, i_byte_ready,
        input  o_dbg_rst, o_dbg_en, o_byte_valid, o_byte_data,
        input  o_state, o_cap_count, o_drop_count
    );
endinterface

// File: rtl/wbdbg_ctrl.sv
// ---------------------------------------------------------------------------
// wbdbg_ctrl
//   Run controller for the Wishbone debug monitor. Sequences a capture
//   session (clear monitor, arm, wait for an address trigger, capture up to
//   a limit of transactions, drain), buffers accepted monitor transactions
//   in a small FIFO and serialises each one MSB first onto the host byte
//   link.
//
//   Ports:
//     i_wb_clk   clock
//     i_wb_rst   asynchronous active-high reset
//     bus        wbdbg_ctrl_if.slave carrying commands, trigger setup,
//                monitor control/strobe, byte link and status counters
// ---------------------------------------------------------------------------
module wbdbg_ctrl #(
    parameter int ADDRBITS = 26,
    parameter int DATABITS = 16,
    parameter int BUSBITS  = 72,
    parameter int DEPTH    = 4,
    parameter int CNTBITS  = 16
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst,
    wbdbg_ctrl_if.slave bus
);
    localparam int NBYTES   = BUSBITS / 8;
    localparam int PTRBITS  = $clog2(DEPTH);
    localparam int BIDXBITS = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ARMED = 3'd2,
        RUN   = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                dbgRst_q, dbgRst_d;
    logic                dbgEn_q, dbgEn_d;
    logic [CNTBITS-1:0]  capCount_q, capCount_d;
    logic [7:0]          dropCount_q, dropCount_d;

    logic [BUSBITS-1:0]  mem_q [DEPTH];
    logic [PTRBITS:0]    wrPtr_q, rdPtr_q;

    logic [BUSBITS-1:0]  shift_q;
    logic [BIDXBITS-1:0] byteIdx_q;
    logic                byteValid_q;

    logic [ADDRBITS-1:0] stbAdr;
    logic                trigHit;
    logic                accept;
    logic                fifoEmpty;
    logic                fifoFull;
    logic                fifoWr;
    logic                fifoDrop;
    logic [CNTBITS-1:0]  capNext;
    logic                limitHit;
    logic                byteTake;
    logic                lastByte;
    logic                serLoad;

    // Trigger compare: only bits selected by the mask take part, so an
    // all-zero mask matches any address.
    assign stbAdr  = bus.i_dbg_txn[2*DATABITS +: ADDRBITS];
    assign trigHit = ((stbAdr ^ bus.i_trig_adr) & bus.i_trig_mask) == '0;

    // A strobe is taken in RUN unconditionally and in ARMED only on a
    // trigger hit; everything else (IDLE, CLEAR, DRAIN) is thrown away.
    assign accept = bus.i_dbg_stb &&
                    ((state_q == RUN) || ((state_q == ARMED) && trigHit));

    // The pointers carry one extra wrap bit so full and empty can be told
    // apart. Fullness is judged on the registered pointers only, so a pop in
    // the same cycle does not make room for a write.
    assign fifoEmpty = (wrPtr_q == rdPtr_q);
    assign fifoFull  = (wrPtr_q[PTRBITS] != rdPtr_q[PTRBITS]) &&
                       (wrPtr_q[PTRBITS-1:0] == rdPtr_q[PTRBITS-1:0]);
    assign fifoWr    = accept && !fifoFull;
    assign fifoDrop  = accept && fifoFull;

    // The write that lands exactly on a nonzero limit ends the capture
    // phase; that transaction itself is still kept.
    assign capNext  = capCount_q + 1'b1;
    assign limitHit = fifoWr && (bus.i_cap_limit != '0) &&
                      (capNext == bus.i_cap_limit);

    // The serialiser reloads from the FIFO head either when idle or in the
    // same cycle the host takes the final byte, so consecutive transactions
    // leave the link with no gap between them.
    assign byteTake = byteValid_q && bus.i_byte_ready;
    assign lastByte = (byteIdx_q == BIDXBITS'(NBYTES - 1));
    assign serLoad  = !fifoEmpty && (!byteValid_q || (byteTake && lastByte));

    // Next-state and counter logic. Stop always beats arm, and an arm seen
    // outside IDLE simply has no effect. Counts are wiped in CLEAR and keep
    // their final values after the session so the host can read them.
    always_comb begin
        state_d     = state_q;
        capCount_d  = capCount_q;
        dropCount_d = dropCount_q;
        case (state_q)
            IDLE: begin
                if (bus.i_cmd_arm && !bus.i_cmd_stop) state_d = CLEAR;
            end
            CLEAR: begin
                capCount_d  = '0;
                dropCount_d = '0;
                state_d     = bus.i_cmd_stop ? IDLE : ARMED;
            end
            ARMED: begin
                if (bus.i_cmd_stop)  state_d = DRAIN;
                else if (accept)     state_d = limitHit ? DRAIN : RUN;
            end
            RUN: begin
                if (bus.i_cmd_stop || limitHit) state_d = DRAIN;
            end
            DRAIN: begin
                if (fifoEmpty && !byteValid_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (fifoWr) capCount_d = capNext;
        if (fifoDrop && (dropCount_q != 8'hFF)) dropCount_d = dropCount_q + 8'd1;
        dbgRst_d = (state_d == CLEAR);
        dbgEn_d  = (state_d == ARMED) || (state_d == RUN);
    end

    // Controller state and its registered outputs. The monitor is held in
    // reset while this block is in reset, so o_dbg_rst only falls on the
    // first clock after release.
    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            state_q     <= IDLE;
            dbgRst_q    <= 1'b1;
            dbgEn_q     <= 1'b0;
            capCount_q  <= '0;
            dropCount_q <= '0;
        end else begin
            state_q     <= state_d;
            dbgRst_q    <= dbgRst_d;
            dbgEn_q     <= dbgEn_d;
            capCount_q  <= capCount_d;
            dropCount_q <= dropCount_d;
        end
    end

    // FIFO pointers. Reset empties the buffer immediately, discarding any
    // transactions of an aborted session.
    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (fifoWr)  wrPtr_q <= wrPtr_q + 1'b1;
            if (serLoad) rdPtr_q <= rdPtr_q + 1'b1;
        end
    end

    // FIFO storage needs no reset: the pointers alone decide what is valid.
    always_ff @(posedge i_wb_clk) begin
        if (fifoWr) mem_q[wrPtr_q[PTRBITS-1:0]] <= bus.i_dbg_txn;
    end

    // Byte serialiser. The outgoing byte is always the top byte of the shift
    // register, which only moves on a host acceptance, so the byte stays
    // stable while the host stalls. Shifting zeros in means the data output
    // reads zero once a transaction has fully left.
    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            byteValid_q <= 1'b0;
            shift_q     <= '0;
            byteIdx_q   <= '0;
        end else if (serLoad) begin
            byteValid_q <= 1'b1;
            shift_q     <= mem_q[rdPtr_q[PTRBITS-1:0]];
            byteIdx_q   <= '0;
        end else if (byteTake) begin
            shift_q <= shift_q << 8;
            if (lastByte) begin
                byteValid_q <= 1'b0;
                byteIdx_q   <= '0;
            end else begin
                byteIdx_q <= byteIdx_q + 1'b1;
            end
        end
    end

    assign bus.o_dbg_rst    = dbgRst_q;
    assign bus.o_dbg_en     = dbgEn_q;
    assign bus.o_byte_valid = byteValid_q;
    assign bus.o_byte_data  = shift_q[BUSBITS-1 -: 8];
    assign bus.o_state      = state_q;
    assign bus.o_cap_count  = capCount_q;
    assign bus.o_drop_count = dropCount_q;

endmodule

// File: tb/tb_wbdbg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wbdbg_ctrl
//   Directed bench for the Wishbone debug run controller. Inputs change one
//   time unit after the rising edge; outputs are read at that point or, for
//   the byte link, on the falling edge.
// ---------------------------------------------------------------------------
module tb_wbdbg_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic [7:0] gotBytes[$];
    logic [7:0] expBytes[$];

    wbdbg_ctrl_if bus ();

    wbdbg_ctrl dut (
        .i_wb_clk (clk),
        .i_wb_rst (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Record every byte the host takes; a transfer happens on the next
    // rising edge whenever valid and ready are both high here.
    always @(negedge clk) begin
        if (bus.o_byte_valid === 1'b1 && bus.i_byte_ready === 1'b1)
            gotBytes.push_back(bus.o_byte_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction layout {tid[12:0], we, adr[25:0], dat_m[15:0], dat_s[15:0]}.
    function automatic logic [71:0] mkTxn(input logic [12:0] tid, input logic [25:0] adr,
                                          input logic [15:0] dm, input logic [15:0] ds);
        return {tid, 1'b1, adr, dm, ds};
    endfunction

    function automatic void addTxnBytes(input logic [71:0] t);
        for (int b = 0; b < 9; b++) expBytes.push_back(t[71 - 8*b -: 8]);
    endfunction

    task automatic armSession(input logic [25:0] adr, input logic [25:0] mask, input logic [15:0] limit);
        bus.i_trig_adr  = adr;
        bus.i_trig_mask = mask;
        bus.i_cap_limit = limit;
        bus.i_cmd_arm   = 1'b1;
        tick();
        bus.i_cmd_arm   = 1'b0;
        tick();
    endtask

    task automatic pulseStop();
        bus.i_cmd_stop = 1'b1;
        tick();
        bus.i_cmd_stop = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        for (int i = 0; i < budget && bus.o_state !== 3'd0; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++; if (bus.o_state !== 3'd0) begin bad++; $display("[TB] FAIL reset_state got=%0d want=0", bus.o_state); end
        total++; if (bus.o_dbg_rst !== 1'b1) begin bad++; $display("[TB] FAIL reset_dbg_rst got=%b want=1", bus.o_dbg_rst); end
        total++; if (bus.o_dbg_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_dbg_en got=%b want=0", bus.o_dbg_en); end
        total++; if (bus.o_byte_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", bus.o_byte_valid); end
        total++; if (bus.o_byte_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_data got=%h want=00", bus.o_byte_data); end
        total++; if (bus.o_cap_count !== 16'd0) begin bad++; $display("[TB] FAIL reset_cap got=%0d want=0", bus.o_cap_count); end
        total++; if (bus.o_drop_count !== 8'd0) begin bad++; $display("[TB] FAIL reset_drop got=%0d want=0", bus.o_drop_count); end
        rst = 1'b0;
        tick();
        total++; if (bus.o_dbg_rst !== 1'b0) begin bad++; $display("[TB] FAIL release_dbg_rst got=%b want=0", bus.o_dbg_rst); end
    endtask

    task automatic test_limit_capture();
        logic [71:0] ta, tb2, tc;
        ta  = mkTxn(13'h0A5, 26'h0123456, 16'hBEEF, 16'hCAFE);
        tb2 = mkTxn(13'h1C3, 26'h2ABCDEF, 16'h1357, 16'h2468);
        tc  = mkTxn(13'h007, 26'h0000040, 16'hFFFF, 16'h0001);
        gotBytes.delete();
        expBytes.delete();
        bus.i_byte_ready = 1'b1;
        bus.i_trig_adr   = '0;
        bus.i_trig_mask  = '0;
        bus.i_cap_limit  = 16'd2;
        bus.i_cmd_arm    = 1'b1;
        tick();
        bus.i_cmd_arm    = 1'b0;
        total++; if (bus.o_state !== 3'd1) begin bad++; $display("[TB] FAIL clear_state got=%0d want=1", bus.o_state); end
        total++; if (bus.o_dbg_rst !== 1'b1) begin bad++; $display("[TB] FAIL clear_dbg_rst got=%b want=1", bus.o_dbg_rst); end
        tick();
        total++; if (bus.o_state !== 3'd2) begin bad++; $display("[TB] FAIL armed_state got=%0d want=2", bus.o_state); end
        total++; if (bus.o_dbg_en !== 1'b1) begin bad++; $display("[TB] FAIL armed_en got=%b want=1", bus.o_dbg_en); end
        total++; if (bus.o_dbg_rst !== 1'b0) begin bad++; $display("[TB] FAIL armed_dbg_rst got=%b want=0", bus.o_dbg_rst); end
        bus.i_dbg_stb = 1'b1;
        bus.i_dbg_txn = ta;
        tick();
        total++; if (bus.o_state !== 3'd3) begin bad++; $display("[TB] FAIL trig_state got=%0d want=3", bus.o_state); end
        total++; if (bus.o_cap_count !== 16'd1) begin bad++; $display("[TB] FAIL trig_cap got=%0d want=1", bus.o_cap_count); end
        total++; if (bus.o_byte_valid !== 1'b0) begin bad++; $display("[TB] FAIL latency_early got=%b want=0", bus.o_byte_valid); end
        bus.i_dbg_txn = tb2;
        tick();
        total++; if (bus.o_state !== 3'd4) begin bad++; $display("[TB] FAIL limit_state got=%0d want=4", bus.o_state); end
        total++; if (bus.o_cap_count !== 16'd2) begin bad++; $display("[TB] FAIL limit_cap got=%0d want=2", bus.o_cap_count); end
        total++; if (bus.o_dbg_en !== 1'b0) begin bad++; $display("[TB] FAIL drain_en got=%b want=0", bus.o_dbg_en); end
        total++; if (bus.o_byte_valid !== 1'b1) begin bad++; $display("[TB] FAIL latency_valid got=%b want=1", bus.o_byte_valid); end
        total++; if (bus.o_byte_data !== ta[71:64]) begin bad++; $display("[TB] FAIL latency_data got=%h want=%h", bus.o_byte_data, ta[71:64]); end
        bus.i_dbg_txn = tc;
        tick();
        bus.i_dbg_stb = 1'b0;
        total++; if (bus.o_cap_count !== 16'd2) begin bad++; $display("[TB] FAIL late_stb_cap got=%0d want=2", bus.o_cap_count); end
        addTxnBytes(ta);
        addTxnBytes(tb2);
        waitIdle(200);
        total++; if (bus.o_state !== 3'd0) begin bad++; $display("[TB] FAIL limit_idle got=%0d want=0", bus.o_state); end
        total++; if (gotBytes.size() !== expBytes.size()) begin bad++; $display("[TB] FAIL limit_nbytes got=%0d want=%0d", gotBytes.size(), expBytes.size()); end
        for (int i = 0; i < expBytes.size() && i < gotBytes.size(); i++) begin
            total++; if (gotBytes[i] !== expBytes[i]) begin bad++; $display("[TB] FAIL limit_byte%0d got=%h want=%h", i, gotBytes[i], expBytes[i]); end
        end
        total++; if (bus.o_drop_count !== 8'd0) begin bad++; $display("[TB] FAIL limit_drop got=%0d want=0", bus.o_drop_count); end
    endtask

    task automatic test_trigger();
        logic [71:0] t0, t1, t2;
        t0 = mkTxn(13'h011, 26'h0000080, 16'hA0A0, 16'h0A0A);
        t1 = mkTxn(13'h022, 26'h0000100, 16'hB1B1, 16'h1B1B);
        t2 = mkTxn(13'h033, 26'h0000104, 16'hC2C2, 16'h2C2C);
        gotBytes.delete();
        expBytes.delete();
        bus.i_byte_ready = 1'b1;
        armSession(26'h0000100, 26'h3FFFFFF, 16'd0);
        bus.i_dbg_stb = 1'b1;
        bus.i_dbg_txn = t0;
        tick();
        total++; if (bus.o_state !== 3'd2) begin bad++; $display("[TB] FAIL nomatch_state got=%0d want=2", bus.o_state); end
        total++; if (bus.o_cap_count !== 16'd0) begin bad++; $display("[TB] FAIL nomatch_cap got=%0d want=0", bus.o_cap_count); end
        bus.i_dbg_txn = t1;
        tick();
        total++; if (bus.o_state !== 3'd3) begin bad++; $display("[TB] FAIL match_state got=%0d want=3", bus.o_state); end
        bus.i_dbg_txn = t2;
        tick();
        bus.i_dbg_stb = 1'b0;
        total++; if (bus.o_cap_count !== 16'd2) begin bad++; $display("[TB] FAIL run_cap got=%0d want=2", bus.o_cap_count); end
        pulseStop();
        total++; if (bus.o_state !== 3'd4) begin bad++; $display("[TB] FAIL trig_stop_state got=%0d want=4", bus.o_state); end
        addTxnBytes(t1);
        addTxnBytes(t2);
        waitIdle(200);
        total++; if (bus.o_state !== 3'd0) begin bad++; $display("[TB] FAIL trig_idle got=%0d want=0", bus.o_state); end
        total++; if (gotBytes.size() !== expBytes.size()) begin bad++; $display("[TB] FAIL trig_nbytes got=%0d want=%0d", gotBytes.size(), expBytes.size()); end
        for (int i = 0; i < expBytes.size() && i < gotBytes.size(); i++) begin
            total++; if (gotBytes[i] !== expBytes[i]) begin bad++; $display("[TB] FAIL trig_byte%0d got=%h want=%h", i, gotBytes[i], expBytes[i]); end
        end
    endtask

    task automatic test_overflow();
        logic [71:0] tx [6];
        for (int k = 0; k < 6; k++)
            tx[k] = mkTxn(13'(k + 1), 26'h0001000 + 26'(k * 4), 16'h1111 * 16'(k + 1), 16'hF0F0 ^ 16'(k));
        gotBytes.delete();
        expBytes.delete();
        bus.i_byte_ready = 1'b0;
        armSession(26'h0, 26'h0, 16'd0);
        for (int k = 0; k < 6; k++) begin
            bus.i_dbg_stb = 1'b1;
            bus.i_dbg_txn = tx[k];
            tick();
        end
        bus.i_dbg_stb = 1'b0;
        total++; if (bus.o_cap_count !== 16'd5) begin bad++; $display("[TB] FAIL ovf_cap got=%0d want=5", bus.o_cap_count); end
        total++; if (bus.o_drop_count !== 8'd1) begin bad++; $display("[TB] FAIL ovf_drop got=%0d want=1", bus.o_drop_count); end
        total++; if (bus.o_byte_data !== tx[0][71:64]) begin bad++; $display("[TB] FAIL stall_data0 got=%h want=%h", bus.o_byte_data, tx[0][71:64]); end
        tick();
        tick();
        tick();
        total++; if (bus.o_byte_valid !== 1'b1) begin bad++; $display("[TB] FAIL stall_valid got=%b want=1", bus.o_byte_valid); end
        total++; if (bus.o_byte_data !== tx[0][71:64]) begin bad++; $display("[TB] FAIL stall_data1 got=%h want=%h", bus.o_byte_data, tx[0][71:64]); end
        bus.i_byte_ready = 1'b1;
        pulseStop();
        for (int k = 0; k < 5; k++) addTxnBytes(tx[k]);
        waitIdle(300);
        total++; if (bus.o_state !== 3'd0) begin bad++; $display("[TB] FAIL ovf_idle got=%0d want=0", bus.o_state); end
        total++; if (gotBytes.size() !== expBytes.size()) begin bad++; $display("[TB] FAIL ovf_nbytes got=%0d want=%0d", gotBytes.size(), expBytes.size()); end
        for (int i = 0; i < expBytes.size() && i < gotBytes.size(); i++) begin
            total++; if (gotBytes[i] !== expBytes[i]) begin bad++; $display("[TB] FAIL ovf_byte%0d got=%h want=%h", i, gotBytes[i], expBytes[i]); end
        end
    endtask

    task automatic test_arm_stop();
        bus.i_cmd_arm  = 1'b1;
        bus.i_cmd_stop = 1'b1;
        tick();
        bus.i_cmd_arm  = 1'b0;
        bus.i_cmd_stop = 1'b0;
        total++; if (bus.o_state !== 3'd0) begin bad++; $display("[TB] FAIL armstop_idle got=%0d want=0", bus.o_state); end
        total++; if (bus.o_dbg_rst !== 1'b0) begin bad++; $display("[TB] FAIL armstop_dbg_rst got=%b want=0", bus.o_dbg_rst); end
        bus.i_cmd_arm = 1'b1;
        tick();
        bus.i_cmd_arm = 1'b0;
        total++; if (bus.o_state !== 3'd1) begin bad++; $display("[TB] FAIL armstop_clear got=%0d want=1", bus.o_state); end
        pulseStop();
        total++; if (bus.o_state !== 3'd0) begin bad++; $display("[TB] FAIL clearstop_state got=%0d want=0", bus.o_state); end
        total++; if (bus.o_dbg_en !== 1'b0) begin bad++; $display("[TB] FAIL clearstop_en0 got=%b want=0", bus.o_dbg_en); end
        tick();
        total++; if (bus.o_dbg_en !== 1'b0) begin bad++; $display("[TB] FAIL clearstop_en1 got=%b want=0", bus.o_dbg_en); end
    endtask

    task automatic test_stop_midbyte();
        logic [71:0] tx [3];
        tx[0] = mkTxn(13'h0F1, 26'h1234567, 16'h9876, 16'h5432);
        tx[1] = mkTxn(13'h0F2, 26'h0ABCDEF, 16'h0102, 16'h0304);
        tx[2] = mkTxn(13'h0F3, 26'h3000001, 16'hA5A5, 16'h5A5A);
        gotBytes.delete();
        expBytes.delete();
        bus.i_byte_ready = 1'b0;
        armSession(26'h0, 26'h0, 16'd0);
        for (int k = 0; k < 3; k++) begin
            bus.i_dbg_stb = 1'b1;
            bus.i_dbg_txn = tx[k];
            tick();
        end
        bus.i_dbg_stb = 1'b0;
        bus.i_byte_ready = 1'b1;
        tick();
        tick();
        tick();
        bus.i_byte_ready = 1'b0;
        total++; if (bus.o_byte_data !== tx[0][47:40]) begin bad++; $display("[TB] FAIL midbyte_data got=%h want=%h", bus.o_byte_data, tx[0][47:40]); end
        pulseStop();
        total++; if (bus.o_state !== 3'd4) begin bad++; $display("[TB] FAIL midstop_state got=%0d want=4", bus.o_state); end
        total++; if (bus.o_byte_valid !== 1'b1) begin bad++; $display("[TB] FAIL midstop_valid got=%b want=1", bus.o_byte_valid); end
        bus.i_byte_ready = 1'b1;
        for (int k = 0; k < 3; k++) addTxnBytes(tx[k]);
        waitIdle(200);
        total++; if (bus.o_state !== 3'd0) begin bad++; $display("[TB] FAIL mid_idle got=%0d want=0", bus.o_state); end
        total++; if (bus.o_cap_count !== 16'd3) begin bad++; $display("[TB] FAIL mid_cap got=%0d want=3", bus.o_cap_count); end
        total++; if (gotBytes.size() !== expBytes.size()) begin bad++; $display("[TB] FAIL mid_nbytes got=%0d want=%0d", gotBytes.size(), expBytes.size()); end
        for (int i = 0; i < expBytes.size() && i < gotBytes.size(); i++) begin
            total++; if (gotBytes[i] !== expBytes[i]) begin bad++; $display("[TB] FAIL mid_byte%0d got=%h want=%h", i, gotBytes[i], expBytes[i]); end
        end
    endtask

    task automatic test_async_reset();
        bus.i_byte_ready = 1'b0;
        armSession(26'h0, 26'h0, 16'd0);
        bus.i_dbg_stb = 1'b1;
        bus.i_dbg_txn = mkTxn(13'h055, 26'h0000200, 16'h4444, 16'h5555);
        tick();
        bus.i_dbg_txn = mkTxn(13'h056, 26'h0000204, 16'h6666, 16'h7777);
        tick();
        bus.i_dbg_stb = 1'b0;
        total++; if (bus.o_state !== 3'd3) begin bad++; $display("[TB] FAIL pre_rst_state got=%0d want=3", bus.o_state); end
        total++; if (bus.o_byte_valid !== 1'b1) begin bad++; $display("[TB] FAIL pre_rst_valid got=%b want=1", bus.o_byte_valid); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (bus.o_byte_valid !== 1'b0) begin bad++; $display("[TB] FAIL arst_valid got=%b want=0", bus.o_byte_valid); end
        total++; if (bus.o_dbg_rst !== 1'b1) begin bad++; $display("[TB] FAIL arst_dbg_rst got=%b want=1", bus.o_dbg_rst); end
        total++; if (bus.o_state !== 3'd0) begin bad++; $display("[TB] FAIL arst_state got=%0d want=0", bus.o_state); end
        total++; if (bus.o_cap_count !== 16'd0) begin bad++; $display("[TB] FAIL arst_cap got=%0d want=0", bus.o_cap_count); end
        tick();
        rst = 1'b0;
        bus.i_byte_ready = 1'b1;
        tick();
        tick();
        total++; if (bus.o_byte_valid !== 1'b0) begin bad++; $display("[TB] FAIL post_rst_valid got=%b want=0", bus.o_byte_valid); end
        total++; if (bus.o_state !== 3'd0) begin bad++; $display("[TB] FAIL post_rst_state got=%0d want=0", bus.o_state); end
    endtask

    initial begin
        bus.i_cmd_arm    = 1'b0;
        bus.i_cmd_stop   = 1'b0;
        bus.i_trig_adr   = '0;
        bus.i_trig_mask  = '0;
        bus.i_cap_limit  = '0;
        bus.i_dbg_stb    = 1'b0;
        bus.i_dbg_txn    = '0;
        bus.i_byte_ready = 1'b0;
        $display("[TB] starting wbdbg_ctrl directed tests");
        test_reset();
        test_limit_capture();
        test_trigger();
        test_overflow();
        test_arm_stop();
        test_stop_midbyte();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
